// File: rtl/bcd_converter.sv
// rtl/bcd_converter.sv - sequential double-dabble binary-to-BCD converter, one bit per clock
// Digits are registered and only updated on the edge that raises done.
module bcd_converter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic [3:0]       hundreds,
  output logic [3:0]       tens,
  output logic [3:0]       ones
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] bin_d;
  logic [11:0]      bcd_q;
  logic [11:0]      bcd_d;
  logic [11:0]      adj_d;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [3:0]       hun_q;
  logic [3:0]       ten_q;
  logic [3:0]       one_q;

  // A nibble >= 5 would reach >= 10 after the shift, so pre-correct it by +3.
  function automatic logic [3:0] adj3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_comb begin
    adj_d = {adj3(bcd_q[11:8]), adj3(bcd_q[7:4]), adj3(bcd_q[3:0])};
    bcd_d = {adj_d[10:0], bin_q[WIDTH-1]};
    bin_d = bin_q << 1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hun_q   <= 4'd0;
      ten_q   <= 4'd0;
      one_q   <= 4'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            bin_q   <= bin_in;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CONV;
          end
        end
        CONV: begin
          bcd_q <= bcd_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            hun_q   <= bcd_d[11:8];
            ten_q   <= bcd_d[7:4];
            one_q   <= bcd_d[3:0];
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign hundreds = hun_q;
  assign tens     = ten_q;
  assign ones     = one_q;

endmodule

// File: tb/tb_bcd_converter.sv
// tb/tb_bcd_converter.sv - scoreboard bench for bcd_converter
// Stimulus pushes expected digits and accept cycle; a negedge monitor pops on done.
module tb_bcd_converter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] bin_in = 8'd0;
  logic       busy;
  logic       done;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;

  bcd_converter #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .hundreds (hundreds),
    .tens     (tens),
    .ones     (ones)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h;
    int t;
    int o;
    int acc;
  } exp_t;

  exp_t q[$];
  int   done_cycles[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_pushed = 0;
  int   busy_run = 0;
  int   last_h = 0;
  int   last_t = 0;
  int   last_o = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_digits", {hundreds, tens, ones}, 0);
      busy_run = 0;
      last_h = 0;
      last_t = 0;
      last_o = 0;
    end else begin
      if (busy && done) chk("busy_and_done", 1, 0);
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("hundreds", int'(hundreds), e.h);
          chk("tens", int'(tens), e.t);
          chk("ones", int'(ones), e.o);
          chk("latency", cyc - e.acc, 8);
          chk("busy_len", busy_run, 8);
          if (hundreds > 4'd9 || tens > 4'd9 || ones > 4'd9)
            chk("digit_range", {hundreds, tens, ones}, -1);
        end
        done_cycles.push_back(cyc);
        last_h = int'(hundreds);
        last_t = int'(tens);
        last_o = int'(ones);
      end else begin
        chk("digits_hold", {hundreds, tens, ones}, (last_h << 8) | (last_t << 4) | last_o);
      end
      busy_run = busy ? busy_run + 1 : 0;
    end
  end

  task automatic push_exp(input int h, input int t, input int o);
    exp_t e;
    e.h = h;
    e.t = t;
    e.o = o;
    e.acc = cyc;
    q.push_back(e);
    n_pushed++;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    @(negedge clk);
  endtask

  task automatic convert(input int v, input int h, input int t, input int o);
    @(negedge clk);
    start = 1'b1;
    bin_in = 8'(v);
    @(posedge clk);
    #1;
    push_exp(h, t, o);
    start = 1'b0;
    bin_in = 8'($urandom_range(0, 255));
    drain();
  endtask

  initial begin
    int d0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    convert(0, 0, 0, 0);
    convert(100, 1, 0, 0);
    convert(199, 1, 9, 9);
    convert(255, 2, 5, 5);

    for (int v = 0; v < 256; v++)
      convert(v, v / 100, (v / 10) % 10, v % 10);

    // start while busy is ignored
    @(negedge clk);
    start = 1'b1;
    bin_in = 8'd37;
    @(posedge clk);
    #1;
    push_exp(0, 3, 7);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    bin_in = 8'd200;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain();
    repeat (12) @(negedge clk);

    // back-to-back with start held high
    @(negedge clk);
    d0 = done_cycles.size();
    start = 1'b1;
    bin_in = 8'd42;
    @(posedge clk);
    #1;
    push_exp(0, 4, 2);
    bin_in = 8'd58;
    repeat (9) @(posedge clk);
    #1;
    push_exp(0, 5, 8);
    start = 1'b0;
    drain();
    if (done_cycles.size() >= d0 + 2)
      chk("b2b_spacing", done_cycles[d0 + 1] - done_cycles[d0], 9);
    else
      chk("b2b_done_count", done_cycles.size() - d0, 2);

    // reset mid-conversion
    @(negedge clk);
    start = 1'b1;
    bin_in = 8'd255;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_digits", {hundreds, tens, ones}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    convert(9, 0, 0, 9);

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    chk("done_total", done_cycles.size(), n_pushed);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bcd_converter.md
# bcd_converter

Sequential binary-to-BCD converter that sits directly downstream of the 8-bit up/down counter and turns its `counter_out` value into three decimal digits for display logic. It uses the shift-and-add-3 (double-dabble) algorithm, one bit per clock, behind a start/busy/done handshake. It holds the last converted result stable between conversions.

## Interface

- `WIDTH`, default 8, binary input width; legal range 4..9 so the result always fits in 3 BCD digits.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  conversion request; sampled only in IDLE.
- `bin_in`  in  WIDTH  unsigned binary value, normally `counter_out`; sampled on the accepting edge only.
- `busy`  out  1  high while a conversion is in progress.
- `done`  out  1  single-cycle pulse when a new result is valid.
- `hundreds`  out  4  BCD hundreds digit, registered.
- `tens`  out  4  BCD tens digit, registered.
- `ones`  out  4  BCD ones digit, registered.

## Operation

- States: IDLE, CONV.
- IDLE: if `start`=1 on a rising edge, then:
  - load `bin_in` into the internal binary shift register;
  - clear the 12-bit BCD scratch register and the bit counter;
  - go to CONV.
- IDLE with `start`=0: hold.
- CONV, one iteration per edge:
  - any scratch nibble ≥5 gets +3, all nibbles in parallel, using the pre-shift values;
  - shift {scratch, binary} left by 1;
  - increment the bit counter.
- After the WIDTH-th iteration:
  - copy the scratch nibbles into `hundreds`/`tens`/`ones`;
  - pulse `done`;
  - return to IDLE.
- Bit counter width is ceil(log2(WIDTH+1)); it never exceeds WIDTH.
- Nibble adjust is 4-bit arithmetic. The ≥5 test guarantees no carry out of a nibble.
- `start` while in CONV is ignored. It is not queued.
- `bin_in` changes during CONV have no effect on the running conversion.
- `hundreds`/`tens`/`ones` change only on the edge that raises `done`. Between conversions they hold the previous result.
- Reset (asynchronous, `rst`=0), including mid-conversion:
  - state goes to IDLE; scratch, shift register and bit counter are cleared;
  - `busy`=0, `done`=0, all digits 0;
  - an aborted conversion produces no `done`.
- On release of `rst`, the first edge with `start`=1 begins a conversion.

## Timing

- Edge E0: `start` accepted in IDLE. `busy` goes high after E0.
- Edges E1..E(WIDTH) perform the iterations.
- After edge E(WIDTH):
  - digits are valid;
  - `done`=1 for exactly one cycle;
  - `busy`=0.
- Latency from the accepting edge to valid digits is WIDTH cycles (8 by default).
- Throughput is one conversion per WIDTH+... cycles: the block is back in IDLE during the `done` cycle. A `start` high in that cycle is accepted on the next edge, so back-to-back conversions start every WIDTH+1 edges, with `busy` low for exactly one cycle in between.
- `busy` and `done` are never high in the same cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

- Reset:
  - assert `rst`=0 for 3 cycles, then release;
  - required: `busy`=0, `done`=0, digits 0/0/0 throughout.
- Single conversions, `bin_in`=0, 100, 199, 255, each with a one-cycle `start`:
  - 0 → 0/0/0; 100 → 1/0/0; 199 → 1/9/9; 255 → 2/5/5;
  - `done` exactly 8 cycles after the accepting edge;
  - `busy` high for exactly 8 cycles.
- Exhaustive sweep, chained to the counter's output, all values 0..255:
  - required: hundreds*100+tens*10+ones equals the input;
  - every digit ≤9.
- Start while busy:
  - convert 37, and pulse `start` with `bin_in`=200 at cycle 4 of CONV;
  - required: result 0/3/7, a single `done`, no second conversion.
- Back-to-back:
  - hold `start`=1 continuously, with `bin_in`=42 then 58;
  - required: results 0/4/2 then 0/5/8;
  - `done` pulses 9 edges apart;
  - the digits hold 0/4/2 until the second `done`.
- Reset mid-conversion:
  - start converting 255, assert `rst`=0 at cycle 5;
  - required: immediate `busy`=0, digits 0/0/0, no `done`;
  - after release, converting 9 gives 0/0/9.
